// File: rtl/sram_pkg.sv
// Shared types and constants for the K6R4016 SRAM arbiter.
// State encoding, bus widths and requester identifiers.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_SAMPLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way requester pick: round-robin or CPU fixed priority.
// Ports: clk, rst_n (async, active low), en_i (grant enable),
//   cpu_req_i/dma_req_i, gnt_valid_o, gnt_id_o (combinational pick).
module rr_arb2
    import sram_pkg::*;
#(
    parameter bit PRIO_CPU = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en_i,
    input  logic    cpu_req_i,
    input  logic    dma_req_i,
    output logic    gnt_valid_o,
    output req_id_e gnt_id_o
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        gnt_valid_o = en_i & (cpu_req_i | dma_req_i);
        gnt_id_o    = REQ_CPU;
        if (cpu_req_i && dma_req_i) begin
            // On a tie the side that did not win last time goes next.
            if (!PRIO_CPU && last_q == REQ_CPU) begin
                gnt_id_o = REQ_DMA;
            end
        end else if (dma_req_i) begin
            gnt_id_o = REQ_DMA;
        end
        last_d = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Reset to DMA so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_DMA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Owner of the external K6R4016 SRAM pins; shares them between CPU and DMA.
// Ports: clk, RST (async, active low), cpu_*/dma_* request ports with
//   req/we/addr/wdata in and rdata/ack out, registered SRAM_* pins, busy.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned WR_CYCLES = 2,
    parameter bit          PRIO_CPU  = 1'b0
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [15:0]        cpu_addr,
    input  logic [SRAM_DW-1:0] cpu_wdata,
    output logic [SRAM_DW-1:0] cpu_rdata,
    output logic               cpu_ack,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [SRAM_AW-1:0] dma_addr,
    input  logic [SRAM_DW-1:0] dma_wdata,
    output logic [SRAM_DW-1:0] dma_rdata,
    output logic               dma_ack,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_O,
    output logic               SRAM_DQ_OE,
    input  logic [SRAM_DW-1:0] SRAM_DQ_I,
    output logic               SRAM_CSX,
    output logic               SRAM_OEX,
    output logic               SRAM_WEX,
    output logic               busy
);

    localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WR_CYCLES - 1);

    state_e             state_q;
    req_id_e            owner_q;
    logic [CW-1:0]      cnt_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_DW-1:0] dq_o_q;
    logic               dq_oe_q;
    logic               csx_q;
    logic               oex_q;
    logic               wex_q;
    logic               busy_q;
    logic               cpu_ack_q;
    logic               dma_ack_q;
    logic [SRAM_DW-1:0] cpu_rdata_q;
    logic [SRAM_DW-1:0] dma_rdata_q;

    logic               arb_en;
    logic               gnt_valid;
    req_id_e            gnt_id;
    logic               gnt_we;
    logic [SRAM_AW-1:0] gnt_addr;
    logic [SRAM_DW-1:0] gnt_wdata;

    assign arb_en = (state_q == IDLE);

    rr_arb2 #(
        .PRIO_CPU (PRIO_CPU)
    ) u_arb (
        .clk         (clk),
        .rst_n       (RST),
        .en_i        (arb_en),
        .cpu_req_i   (cpu_req),
        .dma_req_i   (dma_req),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        gnt_we    = cpu_we;
        gnt_addr  = {2'b00, cpu_addr};
        gnt_wdata = cpu_wdata;
        if (gnt_id == REQ_DMA) begin
            gnt_we    = dma_we;
            gnt_addr  = dma_addr;
            gnt_wdata = dma_wdata;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            owner_q     <= REQ_CPU;
            cnt_q       <= '0;
            addr_q      <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            csx_q       <= 1'b1;
            oex_q       <= 1'b1;
            wex_q       <= 1'b1;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Requester inputs are only looked at here.
                    if (gnt_valid) begin
                        owner_q <= gnt_id;
                        addr_q  <= gnt_addr;
                        busy_q  <= 1'b1;
                        csx_q   <= 1'b0;
                        if (gnt_we) begin
                            dq_o_q  <= gnt_wdata;
                            dq_oe_q <= 1'b1;
                            state_q <= WR_SETUP;
                        end else begin
                            oex_q   <= 1'b0;
                            state_q <= RD_SETUP;
                        end
                    end
                end
                RD_SETUP: begin
                    // Data has had the full setup cycle to settle.
                    if (owner_q == REQ_DMA) begin
                        dma_rdata_q <= SRAM_DQ_I;
                        dma_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= SRAM_DQ_I;
                        cpu_ack_q   <= 1'b1;
                    end
                    state_q <= RD_SAMPLE;
                end
                RD_SAMPLE: begin
                    csx_q   <= 1'b1;
                    oex_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                WR_SETUP: begin
                    wex_q   <= 1'b0;
                    cnt_q   <= CNT_LOAD;
                    state_q <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt_q == '0) begin
                        wex_q   <= 1'b1;
                        state_q <= WR_HOLD;
                        if (owner_q == REQ_DMA) begin
                            dma_ack_q <= 1'b1;
                        end else begin
                            cpu_ack_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WR_HOLD: begin
                    // Releasing the bus here leaves IDLE as turnaround.
                    csx_q   <= 1'b1;
                    dq_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign dma_rdata  = dma_rdata_q;
    assign dma_ack    = dma_ack_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_DQ_O  = dq_o_q;
    assign SRAM_DQ_OE = dq_oe_q;
    assign SRAM_CSX   = csx_q;
    assign SRAM_OEX   = oex_q;
    assign SRAM_WEX   = wex_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pad model, transaction model, directed tests.
// A second instance with CPU fixed priority shares the stimulus.
module tb_sram_arbiter;

    localparam int WR   = 3;
    localparam bit PRIO = 1'b0;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [17:0] dma_addr = '0;
    logic [15:0] dma_wdata = '0;

    logic [15:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
    logic        SRAM_DQ_OE, SRAM_CSX, SRAM_OEX, SRAM_WEX, busy;

    logic [15:0] p_cpu_rdata, p_dma_rdata, p_dq_o;
    logic        p_cpu_ack, p_dma_ack, p_dq_oe;
    logic        p_csx, p_oex, p_wex, p_busy;
    logic [17:0] p_addr;

    always #5 clk = ~clk;

    sram_arbiter #(.WR_CYCLES(WR), .PRIO_CPU(PRIO)) dut (
        .clk(clk), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_I(SRAM_DQ_I),
        .SRAM_CSX(SRAM_CSX), .SRAM_OEX(SRAM_OEX), .SRAM_WEX(SRAM_WEX),
        .busy(busy)
    );

    sram_arbiter #(.WR_CYCLES(2), .PRIO_CPU(1'b1)) dut_p (
        .clk(clk), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(p_cpu_rdata), .cpu_ack(p_cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(p_dma_rdata), .dma_ack(p_dma_ack),
        .SRAM_ADDR(p_addr), .SRAM_DQ_O(p_dq_o),
        .SRAM_DQ_OE(p_dq_oe), .SRAM_DQ_I(16'h0000),
        .SRAM_CSX(p_csx), .SRAM_OEX(p_oex), .SRAM_WEX(p_wex),
        .busy(p_busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] init_word(input logic [17:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {14'h0, a[17:16]};
    endfunction

    // SRAM pad model
    logic [15:0] sram    [0:262143];
    bit          sram_wr [0:262143];

    assign SRAM_DQ_I = (!SRAM_CSX && !SRAM_OEX)
        ? (sram_wr[SRAM_ADDR] ? sram[SRAM_ADDR] : init_word(SRAM_ADDR))
        : 16'hDEAD;

    always @(posedge clk) begin
        if (RST && !SRAM_CSX && !SRAM_WEX && SRAM_DQ_OE) begin
            sram[SRAM_ADDR]    <= SRAM_DQ_O;
            sram_wr[SRAM_ADDR] <= 1'b1;
        end
    end

    // Transaction model: an access occupies m_len cycles after its grant,
    // the last of which carries the ack.
    logic [15:0] e_mem [0:262143];
    bit          e_wr  [0:262143];
    int          m_left, m_len;
    logic        m_own, m_we, m_last;
    logic [17:0] m_addr;
    logic [15:0] m_data, m_rd, e_crd, e_drd;

    logic        m_pick, pick_we;
    logic [17:0] pick_addr;
    logic [15:0] pick_wd;

    assign m_pick = (cpu_req && dma_req) ? (PRIO ? 1'b0 : !m_last) : dma_req;
    assign pick_we   = m_pick ? dma_we : cpu_we;
    assign pick_addr = m_pick ? dma_addr : {2'b00, cpu_addr};
    assign pick_wd   = m_pick ? dma_wdata : cpu_wdata;

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            m_left <= 0;
            m_len  <= 0;
            m_last <= 1'b1;
            m_own  <= 1'b0;
            m_we   <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_rd   <= '0;
            e_crd  <= '0;
            e_drd  <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 2 && !m_we) begin
                if (m_own) e_drd <= m_rd;
                else e_crd <= m_rd;
            end
        end else if (cpu_req || dma_req) begin
            m_own  <= m_pick;
            m_last <= m_pick;
            m_we   <= pick_we;
            m_addr <= pick_addr;
            if (pick_we) begin
                m_data           <= pick_wd;
                e_mem[pick_addr] <= pick_wd;
                e_wr[pick_addr]  <= 1'b1;
                m_left           <= WR + 2;
                m_len            <= WR + 2;
            end else begin
                m_rd   <= e_wr[pick_addr] ? e_mem[pick_addr]
                                          : init_word(pick_addr);
                m_left <= 2;
                m_len  <= 2;
            end
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (RST && chk_on) begin
            bit e_csx, e_oex, e_wex, e_oe;
            int p;
            e_csx = 1'b1;
            e_oex = 1'b1;
            e_wex = 1'b1;
            e_oe  = 1'b0;
            p     = 0;
            if (m_left > 0) begin
                p     = m_len - m_left + 1;
                e_csx = 1'b0;
                if (m_we) begin
                    e_oe  = 1'b1;
                    e_wex = (p >= 2 && p <= WR + 1) ? 1'b0 : 1'b1;
                end else begin
                    e_oex = 1'b0;
                end
            end
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("cpu_ack", 32'(cpu_ack), 32'(m_left == 1 && !m_own));
            chk("dma_ack", 32'(dma_ack), 32'(m_left == 1 && m_own));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
            chk("dma_rdata", 32'(dma_rdata), 32'(e_drd));
            chk("csx", 32'(SRAM_CSX), 32'(e_csx));
            chk("oex", 32'(SRAM_OEX), 32'(e_oex));
            chk("wex", 32'(SRAM_WEX), 32'(e_wex));
            chk("dq_oe", 32'(SRAM_DQ_OE), 32'(e_oe));
            chk("addr", 32'(SRAM_ADDR), 32'(m_addr));
            if (e_oe) chk("dq_o", 32'(SRAM_DQ_O), 32'(m_data));
            chk("contention", 32'(SRAM_DQ_OE && !SRAM_OEX), 32'(0));
        end
    end

    task automatic access(input bit dma, input bit we,
                          input logic [17:0] addr, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd,
                          output int wex_lo, output int oe_hi);
        lat    = -1;
        rd     = '0;
        wex_lo = 0;
        oe_hi  = 0;
        if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr[15:0]; cpu_wdata = wd;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (!SRAM_WEX) wex_lo++;
            if (SRAM_DQ_OE) oe_hi++;
            if (dma ? dma_ack : cpu_ack) begin
                lat = i;
                rd  = dma ? dma_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        #1 RST = 1'b0;
        #2 RST = 1'b1;
    endtask

    int          lat, wlo, ohi, n_ack, p_cpu, p_dma;
    logic [15:0] rd;
    int          order [$];

    initial begin
        @(posedge clk); #1;
        chk("rst csx", 32'(SRAM_CSX), 32'(1));
        chk("rst oex", 32'(SRAM_OEX), 32'(1));
        chk("rst wex", 32'(SRAM_WEX), 32'(1));
        chk("rst dq_oe", 32'(SRAM_DQ_OE), 32'(0));
        chk("rst addr", 32'(SRAM_ADDR), 32'(0));
        chk("rst dq_o", 32'(SRAM_DQ_O), 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst acks", 32'({cpu_ack, dma_ack}), 32'(0));
        chk("rst rdata", 32'({cpu_rdata, dma_rdata}), 32'(0));
        #1 RST = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // 1: CPU write then read back
        access(1'b0, 1'b1, 18'h00005, 16'h1234, lat, rd, wlo, ohi);
        chk("t1 write latency", 32'(lat), 32'(WR + 2));
        chk("t4 wex low cycles", 32'(wlo), 32'(WR));
        chk("t4 dq_oe cycles", 32'(ohi), 32'(WR + 2));
        access(1'b0, 1'b0, 18'h00005, 16'h0000, lat, rd, wlo, ohi);
        chk("t1 read latency", 32'(lat), 32'(2));
        chk("t1 read data", 32'(rd), 32'h1234);
        chk("t1 read no dq_oe", 32'(ohi), 32'(0));
        chk("t1 sram addr", 32'(SRAM_ADDR), 32'h00005);

        // 2: DMA write at top, CPU read cannot reach it
        access(1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, lat, rd, wlo, ohi);
        chk("t2 dma write latency", 32'(lat), 32'(WR + 2));
        access(1'b0, 1'b0, 18'h0FFFF, 16'h0000, lat, rd, wlo, ohi);
        chk("t2 cpu read zero-ext", 32'(rd), 32'h5A3C);
        chk("t2 cpu read addr", 32'(SRAM_ADDR), 32'h0FFFF);
        access(1'b1, 1'b0, 18'h3FFFF, 16'h0000, lat, rd, wlo, ohi);
        chk("t2 dma read back", 32'(rd), 32'hBEEF);

        // 3: tie, fresh from reset
        do_reset();
        @(posedge clk); #1;
        cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 16'h0005; dma_addr = 18'h3FFFF;
        cpu_req = 1'b1; dma_req = 1'b1;
        p_cpu = 0; p_dma = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) order.push_back(0);
            if (dma_ack) order.push_back(1);
            if (p_cpu_ack) p_cpu++;
            if (p_dma_ack) p_dma++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("t3 grant count", 32'(order.size()), 32'(4));
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("t3 grant order", 32'(order[i]), 32'(i % 2));
        chk("t3 prio cpu acks", 32'(p_cpu), 32'(4));
        chk("t3 prio dma acks", 32'(p_dma), 32'(0));
        repeat (3) @(posedge clk);
        #1;

        // 5: reset in the middle of a write pulse
        cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h7777;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5 in pulse", 32'(SRAM_WEX), 32'(0));
        #1 RST = 1'b0;
        #1;
        chk("t5 csx idle", 32'(SRAM_CSX), 32'(1));
        chk("t5 wex idle", 32'(SRAM_WEX), 32'(1));
        chk("t5 dq_oe idle", 32'(SRAM_DQ_OE), 32'(0));
        chk("t5 busy idle", 32'(busy), 32'(0));
        cpu_req = 1'b0;
        RST = 1'b1;
        n_ack = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (cpu_ack) n_ack++;
        end
        chk("t5 no ack", 32'(n_ack), 32'(0));
        access(1'b0, 1'b0, 18'h00200, 16'h0000, lat, rd, wlo, ohi);
        chk("t5 next latency", 32'(lat), 32'(2));
        chk("t5 next data", 32'(rd), 32'hA7C3);

        // 6: inputs change after grant
        cpu_we = 1'b1; cpu_addr = 16'h0033; cpu_wdata = 16'hC0DE;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cpu_addr = 16'h0044; cpu_wdata = 16'h0BAD; cpu_req = 1'b0;
        cpu_we = 1'b0;
        n_ack = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cpu_ack) n_ack++;
        end
        chk("t6 single ack", 32'(n_ack), 32'(1));
        access(1'b0, 1'b0, 18'h00033, 16'h0000, lat, rd, wlo, ohi);
        chk("t6 latched data", 32'(rd), 32'hC0DE);
        access(1'b0, 1'b0, 18'h00044, 16'h0000, lat, rd, wlo, ohi);
        chk("t6 late addr untouched", 32'(rd), 32'hA587);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
